// File: rtl/image_capture_bram.sv
// Frame-capture sink: writes one raster frame of 24-bit RGB pixels into an internal BRAM
// and exposes a 1-cycle-latency readback port. Optional checksum: `CAPTURE_CHECKSUM_EN.
module image_capture_bram #(
  parameter int unsigned IMAGE_WIDTH  = 512,
  parameter int unsigned IMAGE_HEIGHT = 512,
  parameter int unsigned IMAGE_SIZE   = IMAGE_WIDTH * IMAGE_HEIGHT,
  parameter int unsigned ADDR_W       = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [23:0]       pixel_in,
  input  logic              pixel_valid_in,
  output logic              pixel_ready_out,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       col_out,
  output logic [15:0]       row_out,
  output logic [15:0]       drop_count,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [23:0]       rd_data,
  output logic              rd_valid,
  output logic [31:0]       checksum
);

  // Index width sized to the frame so the array is addressed without truncation warnings.
  localparam int unsigned IdxW = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StCapture = 2'd1;
  localparam logic [1:0] StDone    = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       col_q, col_d;
  logic [15:0]       row_q, row_d;
  logic [15:0]       drop_q, drop_d;
  logic [23:0]       rd_data_q;
  logic              rd_valid_q;
  logic              xfer;
  logic              last_pix;
  logic              last_col;
  logic              rd_in_range;

  logic [23:0] mem [IMAGE_SIZE];

  assign pixel_ready_out = (state_q == StCapture);
  assign busy            = (state_q == StCapture);
  assign frame_done      = (state_q == StDone);
  assign xfer            = pixel_valid_in & pixel_ready_out;
  assign last_pix        = (wr_addr_q == ADDR_W'(IMAGE_SIZE - 1));
  assign last_col        = (col_q == 16'(IMAGE_WIDTH - 1));
  assign rd_in_range     = (32'(rd_addr) < IMAGE_SIZE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start) state_d = StCapture;
      StCapture: if (xfer && last_pix) state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_addr_d = wr_addr_q;
    col_d     = col_q;
    row_d     = row_q;
    if (state_q == StIdle && start) begin
      wr_addr_d = '0;
      col_d     = '0;
      row_d     = '0;
    end else if (xfer) begin
      wr_addr_d = wr_addr_q + 1'b1;
      if (last_col) begin
        col_d = '0;
        row_d = row_q + 16'd1;
      end else begin
        col_d = col_q + 16'd1;
      end
    end
  end

  // Counts every presented-but-refused pixel in any state; only rst clears it.
  always_comb begin
    drop_d = drop_q;
    if (pixel_valid_in && !pixel_ready_out && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      wr_addr_q <= '0;
      col_q     <= '0;
      row_q     <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      col_q     <= col_d;
      row_q     <= row_d;
      drop_q    <= drop_d;
    end
  end

  // Frame buffer contents survive reset.
  always_ff @(posedge clk) begin
    if (xfer) mem[wr_addr_q[IdxW-1:0]] <= pixel_in;
  end

  // Non-blocking read of the old word gives read-before-write on a same-address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) rd_data_q <= rd_in_range ? mem[rd_addr[IdxW-1:0]] : 24'h0;
    end
  end

`ifdef CAPTURE_CHECKSUM_EN
  logic [31:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (state_q == StIdle && start) begin
      checksum_d = '0;
    end else if (xfer) begin
      checksum_d = checksum_q + 32'(pixel_in[23:16]) + 32'(pixel_in[15:8])
                   + 32'(pixel_in[7:0]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) checksum_q <= '0;
    else     checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`else
  assign checksum = 32'h0;
`endif

  assign col_out    = col_q;
  assign row_out    = row_q;
  assign drop_count = drop_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;

endmodule

// File: tb/tb_image_capture_bram.sv
// Directed bench for image_capture_bram on a 4x2 frame; readback data is checked through a
// scoreboard queue filled when a read is issued and drained when rd_valid comes back.
module tb_image_capture_bram;

  localparam int unsigned W = 4;
  localparam int unsigned H = 2;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [23:0]   pixel_in = '0;
  logic          pixel_valid_in = 1'b0;
  logic          pixel_ready_out;
  logic          busy;
  logic          frame_done;
  logic [15:0]   col_out;
  logic [15:0]   row_out;
  logic [15:0]   drop_count;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [23:0]   rd_data;
  logic          rd_valid;
  logic [31:0]   checksum;

  int errors = 0;
  int checks = 0;
  logic [23:0] model [8];
  logic [23:0] sb [$];

  image_capture_bram #(
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .ADDR_W      (AW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .pixel_in       (pixel_in),
    .pixel_valid_in (pixel_valid_in),
    .pixel_ready_out(pixel_ready_out),
    .busy           (busy),
    .frame_done     (frame_done),
    .col_out        (col_out),
    .row_out        (row_out),
    .drop_count     (drop_count),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .checksum       (checksum)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; any read issued before the edge is scored right after it.
  task automatic tick();
    logic issued;
    logic [23:0] exp;
    issued = rd_en;
    @(posedge clk);
    #1;
    if (issued) begin
      check("rd_valid", 32'(rd_valid), 32'd1);
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        check("rd_data", 32'(rd_data), 32'(exp));
      end else begin
        check("sb_underflow", 32'(sb.size()), 32'd1);
      end
    end
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [23:0] exp);
    rd_en   = 1'b1;
    rd_addr = a;
    sb.push_back(exp);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic arm();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    logic [23:0] p;
    logic [23:0] old2;

    // Reset state
    tick(); tick();
    check("rst_ready", 32'(pixel_ready_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(frame_done), 0);
    check("rst_rdvalid", 32'(rd_valid), 0);
    check("rst_col", 32'(col_out), 0);
    check("rst_row", 32'(row_out), 0);
    check("rst_drop", 32'(drop_count), 0);
    check("rst_rddata", 32'(rd_data), 0);
    check("rst_cksum", checksum, 0);
    rst = 1'b0;
    tick();

    // Test 1/2: back-to-back frame, col/row tracking, readback
    arm();
    check("t1_busy", 32'(busy), 1);
    for (int i = 0; i < 8; i++) begin
      p = {8'(i + 1), 8'(i + 2), 8'(i + 3)};
      model[i] = p;
      pixel_in = p;
      pixel_valid_in = 1'b1;
      tick();
      if (i == 2) begin
        check("t2_col3", 32'(col_out), 3);
        check("t2_row0", 32'(row_out), 0);
      end
      if (i == 3) begin
        check("t2_col0", 32'(col_out), 0);
        check("t2_row1", 32'(row_out), 1);
      end
      if (i < 7) check("t1_no_done", 32'(frame_done), 0);
    end
    pixel_valid_in = 1'b0;
    check("t1_done", 32'(frame_done), 1);
    check("t1_ready_drop", 32'(pixel_ready_out), 0);
    check("t1_done_col", 32'(col_out), 0);
    check("t1_done_row", 32'(row_out), H);
    tick();
    check("t1_done_pulse", 32'(frame_done), 0);
    check("t1_idle_busy", 32'(busy), 0);
    for (int a = 0; a < 8; a++) rd(AW'(a), model[a]);
    rd(AW'(8), 24'h0);
    tick();
    check("t1_rdvalid_low", 32'(rd_valid), 0);
    check("t1_rddata_hold", 32'(rd_data), 0);

    // Test 3: drops in IDLE
    pixel_in = 24'hDEAD00;
    pixel_valid_in = 1'b1;
    repeat (5) tick();
    pixel_valid_in = 1'b0;
    check("t3_drop5", 32'(drop_count), 5);
    rd(AW'(0), model[0]);

    // Test 4: valid toggled during capture, then a 9th pixel held
    arm();
    for (int i = 0; i < 8; i++) begin
      p = 24'hA00000 + 24'(i);
      model[i] = p;
      pixel_in = p;
      pixel_valid_in = 1'b1;
      tick();
      pixel_valid_in = 1'b0;
      if (i == 0) begin
        tick();
        check("t4_stall_col", 32'(col_out), 1);
      end else if (i < 7) begin
        tick();
      end
    end
    check("t4_done", 32'(frame_done), 1);
    pixel_in = 24'hBADBAD;
    pixel_valid_in = 1'b1;
    tick();
    pixel_valid_in = 1'b0;
    check("t4_drop9", 32'(drop_count), 6);
    for (int a = 0; a < 8; a++) rd(AW'(a), model[a]);

    // Test 5: reset mid-frame
    arm();
    for (int i = 0; i < 3; i++) begin
      p = 24'h550000 + 24'(i << 4);
      model[i] = p;
      pixel_in = p;
      pixel_valid_in = 1'b1;
      tick();
    end
    pixel_valid_in = 1'b0;
    rst = 1'b1;
    #1;
    check("t5_busy", 32'(busy), 0);
    check("t5_col", 32'(col_out), 0);
    check("t5_row", 32'(row_out), 0);
    check("t5_done", 32'(frame_done), 0);
    tick();
    rst = 1'b0;
    tick();
    check("t5_no_done", 32'(frame_done), 0);
    for (int a = 0; a < 4; a++) rd(AW'(a), model[a]);

    // Test 6: all-white checksum, read-before-write on address 2
    arm();
    old2 = model[2];
    for (int i = 0; i < 8; i++) begin
      pixel_in = 24'hFFFFFF;
      pixel_valid_in = 1'b1;
      if (i == 2) begin
        rd_en = 1'b1;
        rd_addr = AW'(2);
        sb.push_back(old2);
      end
      tick();
      rd_en = 1'b0;
      model[i] = 24'hFFFFFF;
    end
    pixel_valid_in = 1'b0;
    check("t6_done", 32'(frame_done), 1);
`ifdef CAPTURE_CHECKSUM_EN
    check("t6_cksum", checksum, 32'd6120);
`else
    check("t6_cksum", checksum, 32'd0);
`endif
    tick();
`ifdef CAPTURE_CHECKSUM_EN
    check("t6_cksum_hold", checksum, 32'd6120);
`else
    check("t6_cksum_hold", checksum, 32'd0);
`endif
    rd(AW'(2), 24'hFFFFFF);
    rd(AW'(15), 24'h0);

    // Test 3b: drop counter saturation
    pixel_valid_in = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    pixel_valid_in = 1'b0;
    check("t3_sat", 32'(drop_count), 32'hFFFF);
    check("sb_empty", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
